alu_cmd_issuer: RTL and testbench

- Initiator side of the ALU operand interface.
- Accepts ALU commands (ctrl, a, b, tag) over a valid/ready stream and buffers them in a small FIFO.
- Issues one command at a time to the external combinational 16-bit ALU, then captures s/zero/overflow.
- Returns each result over a valid/ready stream and keeps sticky statistics counters.

---
 rtl/alu_cmd_issuer.sv | 137 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues them one at a time to an external ALU, returns tagged results and keeps statistics
// Ports: cmd_* command stream in (cmd_ready = !full), alu_* registered operands out / combinational ALU result in,
//        res_* result stream out (held until res_ready), clear_stats/ops_done/ovf_count statistics.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_ctrl,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_ctrl,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic [15:0]      alu_s,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_s,
    output logic             res_zero,
    output logic             res_overflow,
    output logic             res_illegal,
    output logic [TAG_W-1:0] res_tag,
    input  logic             clear_stats,
    output logic [15:0]      ops_done,
    output logic [15:0]      ovf_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q;
    logic [3:0]       ctrl_mem [DEPTH];
    logic [15:0]      a_mem    [DEPTH];
    logic [15:0]      b_mem    [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic [3:0]       alu_ctrl_q;
    logic [15:0]      alu_a_q, alu_b_q;
    logic [TAG_W-1:0] tag_q;
    logic             res_valid_q, res_zero_q, res_ovf_q, res_illegal_q;
    logic [15:0]      res_s_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [15:0]      ops_cnt_q, ovf_cnt_q;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             empty, full, push, pop, res_hs;

    assign wr_idx = wr_q[AW-1:0];
    assign rd_idx = rd_q[AW-1:0];
    assign empty  = wr_q == rd_q;
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
    assign push   = cmd_valid && !full;
    assign res_hs = res_valid_q && res_ready;
    // Pop either from idle or straight out of RESP on the result handshake.
    assign pop    = !empty && (state_q == IDLE || res_hs);

    assign cmd_ready    = !full;
    assign alu_ctrl     = alu_ctrl_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign res_valid    = res_valid_q;
    assign res_s        = res_s_q;
    assign res_zero     = res_zero_q;
    assign res_overflow = res_ovf_q;
    assign res_illegal  = res_illegal_q;
    assign res_tag      = res_tag_q;
    assign ops_done     = ops_cnt_q;
    assign ovf_count    = ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_idx] <= cmd_ctrl;
            a_mem[wr_idx]    <= cmd_a;
            b_mem[wr_idx]    <= cmd_b;
            tag_mem[wr_idx]  <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_q          <= '0;
            rd_q          <= '0;
            alu_ctrl_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            tag_q         <= '0;
            res_valid_q   <= 1'b0;
            res_s_q       <= '0;
            res_zero_q    <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_illegal_q <= 1'b0;
            res_tag_q     <= '0;
            ops_cnt_q     <= '0;
            ovf_cnt_q     <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q       <= rd_q + 1'b1;
                alu_ctrl_q <= ctrl_mem[rd_idx];
                alu_a_q    <= a_mem[rd_idx];
                alu_b_q    <= b_mem[rd_idx];
                tag_q      <= tag_mem[rd_idx];
            end
            case (state_q)
                IDLE: if (!empty) state_q <= ISSUE;
                ISSUE: begin
                    res_s_q       <= alu_s;
                    res_zero_q    <= alu_zero;
                    res_ovf_q     <= alu_overflow;
                    res_illegal_q <= alu_ctrl_q inside {4'd7, 4'd11, 4'd13, 4'd15};
                    res_tag_q     <= tag_q;
                    res_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= empty ? IDLE : ISSUE;
                end
                default: state_q <= IDLE;
            endcase
            if (clear_stats) begin
                ops_cnt_q <= '0;
                ovf_cnt_q <= '0;
            end else if (res_hs) begin
                ops_cnt_q <= ops_cnt_q + 1'b1;
                if (res_ovf_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench with a queue-based result model for alu_cmd_issuer
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [3:0]       cmd_ctrl;
    logic [15:0]      cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0]       alu_ctrl;
    logic [15:0]      alu_a, alu_b, alu_s;
    logic             alu_zero, alu_overflow;
    logic             res_valid, res_ready, res_zero, res_overflow, res_illegal;
    logic [15:0]      res_s;
    logic [TAG_W-1:0] res_tag;
    logic             clear_stats;
    logic [15:0]      ops_done, ovf_count;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
        .res_zero(res_zero), .res_overflow(res_overflow), .res_illegal(res_illegal),
        .res_tag(res_tag), .clear_stats(clear_stats),
        .ops_done(ops_done), .ovf_count(ovf_count)
    );

    // External 16-bit ALU: 0 sub, 1 add, a few logic ops, unassigned opcodes return 0.
    function automatic logic [17:0] alu_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic o;
        s = '0;
        o = 1'b0;
        case (c)
            4'd0: begin s = a - b; o = (a[15] != b[15]) && (s[15] != a[15]); end
            4'd1: begin s = a + b; o = (a[15] == b[15]) && (s[15] != a[15]); end
            4'd2: s = a & b;
            4'd3: s = a | b;
            4'd4: s = a ^ b;
            4'd5: s = a << b[3:0];
            4'd6: s = a >> b[3:0];
            4'd8: s = ~a;
            default: s = '0;
        endcase
        return {s, s == 16'h0, o};
    endfunction

    assign {alu_s, alu_zero, alu_overflow} = alu_fn(alu_ctrl, alu_a, alu_b);

    typedef struct packed {
        logic [15:0]      s;
        logic             z;
        logic             o;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t        exp_q[$];
    res_t        e, held;
    logic        stalled = 1'b0;
    logic [15:0] m_ops = '0, m_ovf = '0;
    int          vectors = 0, miscompares = 0;

    function automatic res_t mk(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
        res_t r;
        {r.s, r.z, r.o} = alu_fn(c, a, b);
        r.ill = c inside {4'd7, 4'd11, 4'd13, 4'd15};
        r.tag = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted command yields exactly one result, in order; counters follow handshakes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ops = '0;
            m_ovf = '0;
            stalled = 1'b0;
        end else begin
            chk("ops_done", ops_done, m_ops);
            chk("ovf_count", ovf_count, m_ovf);
            if (stalled) begin
                chk("stall_valid", res_valid, 1);
                chk("stall_s", res_s, held.s);
                chk("stall_zero", res_zero, held.z);
                chk("stall_ovf", res_overflow, held.o);
                chk("stall_ill", res_illegal, held.ill);
                chk("stall_tag", res_tag, held.tag);
            end
            if (exp_q.size() < DEPTH) chk("cmd_ready_room", cmd_ready, 1);
            if (exp_q.size() == DEPTH + 1) chk("cmd_ready_full", cmd_ready, 0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", res_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_s", res_s, e.s);
                    chk("res_zero", res_zero, e.z);
                    chk("res_overflow", res_overflow, e.o);
                    chk("res_illegal", res_illegal, e.ill);
                    chk("res_tag", res_tag, e.tag);
                    if (!clear_stats) begin
                        m_ops = m_ops + 16'd1;
                        if (e.o && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
                    end
                end
            end
            if (clear_stats) begin
                m_ops = '0;
                m_ovf = '0;
            end
            stalled = res_valid && !res_ready;
            held = '{s: res_s, z: res_zero, o: res_overflow, ill: res_illegal, tag: res_tag};
            if (cmd_valid && cmd_ready) exp_q.push_back(mk(cmd_ctrl, cmd_a, cmd_b, cmd_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_ctrl = c;
        cmd_a = a;
        cmd_b = b;
        cmd_tag = t;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) chk("push_timeout", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        if (!res_valid) chk("res_timeout", res_valid, 1);
    endtask

    initial begin
        int tags[$];
        int cyc[$];
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_ctrl = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_tag = '0;
        res_ready = 1'b0;
        clear_stats = 1'b0;
        step();
        step();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_res_s", res_s, 0);
        chk("rst_res_flags", {res_zero, res_overflow, res_illegal}, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_ovf", ovf_count, 0);
        rst = 1'b0;
        res_ready = 1'b1;

        // Single command latency: handshake E0, pop E1, capture E2.
        push(4'd1, 16'h0003, 16'h0004, 4'd5);
        chk("lat_e0_valid", res_valid, 0);
        step();
        chk("lat_e1_valid", res_valid, 0);
        chk("lat_e1_alu_ctrl", alu_ctrl, 1);
        chk("lat_e1_alu_a", alu_a, 16'h0003);
        chk("lat_e1_alu_b", alu_b, 16'h0004);
        step();
        chk("lat_e2_valid", res_valid, 1);
        chk("t1_s", res_s, 16'h0007);
        chk("t1_flags", {res_zero, res_overflow, res_illegal}, 0);
        chk("t1_tag", res_tag, 5);
        step();
        chk("t1_valid_drop", res_valid, 0);
        chk("t1_ops", ops_done, 1);
        chk("t1_alu_hold", alu_a, 16'h0003);

        // Overflowing add, then zero-result sub, returned in order.
        push(4'd1, 16'h7FFF, 16'h0001, 4'd1);
        push(4'd0, 16'h0005, 16'h0005, 4'd2);
        wait_res();
        chk("t2a_s", res_s, 16'h8000);
        chk("t2a_ovf", res_overflow, 1);
        chk("t2a_tag", res_tag, 1);
        step();
        wait_res();
        chk("t2b_s", res_s, 16'h0000);
        chk("t2b_zero", res_zero, 1);
        chk("t2b_tag", res_tag, 2);
        step();
        chk("t2_ovf_count", ovf_count, 1);
        chk("t2_ops", ops_done, 3);

        // Stall: one in flight plus a full FIFO, then drain at one result per two cycles.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'd2, 16'h0100 + 16'(i), 16'hFFFF, TAG_W'(10 + i));
        chk("full_after5", cmd_ready, 0);
        repeat (4) step();
        chk("stall_head_tag", res_tag, 10);
        chk("stall_full", cmd_ready, 0);
        chk("stall_alu_a", alu_a, 16'h0100);
        res_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (res_valid) begin
                tags.push_back(int'(res_tag));
                cyc.push_back(c);
            end
            step();
        end
        chk("drain_count", tags.size(), 5);
        for (int i = 0; i < tags.size() && i < 5; i++) chk("drain_tag", tags[i], 10 + i);
        for (int i = 1; i < cyc.size(); i++) chk("drain_spacing", cyc[i] - cyc[i-1], 2);

        // Unassigned opcode still issued; ALU returns 0.
        push(4'd7, 16'h1234, 16'h0055, 4'd3);
        wait_res();
        chk("ill_s", res_s, 0);
        chk("ill_flag", res_illegal, 1);
        chk("ill_zero", res_zero, 1);
        chk("ill_tag", res_tag, 3);
        step();

        // Reset with one result pending and three queued.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd1, 16'(i), 16'h0001, TAG_W'(4 + i));
        repeat (3) step();
        chk("pre_rst_valid", res_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_ops", ops_done, 0);
        chk("mid_rst_ovf", ovf_count, 0);
        res_ready = 1'b1;
        push(4'd1, 16'h0002, 16'h0002, 4'd9);
        wait_res();
        chk("post_rst_tag", res_tag, 9);
        chk("post_rst_s", res_s, 16'h0004);
        step();
        repeat (6) begin
            chk("no_stale", res_valid, 0);
            step();
        end

        // Preload counters near their limits: ops wraps, ovf saturates.
        force dut.ovf_cnt_q = 16'hFFFE;
        force dut.ops_cnt_q = 16'hFFFF;
        m_ovf = 16'hFFFE;
        m_ops = 16'hFFFF;
        #1;
        release dut.ovf_cnt_q;
        release dut.ops_cnt_q;
        for (int i = 0; i < 3; i++) push(4'd1, 16'h7FFF, 16'h0001, TAG_W'(i));
        for (int i = 0; i < 3; i++) begin
            wait_res();
            step();
        end
        chk("sat_ovf", ovf_count, 16'hFFFF);
        chk("wrap_ops", ops_done, 16'h0002);

        // clear_stats wins over a same-edge handshake.
        res_ready = 1'b0;
        push(4'd1, 16'h7FFF, 16'h0001, 4'd6);
        wait_res();
        res_ready = 1'b1;
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clr_ops", ops_done, 0);
        chk("clr_ovf", ovf_count, 0);
        chk("clr_valid", res_valid, 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
